// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit. It computes MULT/MULTU/DIV/DIVU results and handles
// MTHI/MTLO, driving the HI/LO register write port.
// The write port is registered and launched on posedge, so the falling-edge HI/LO register
// sees values that are stable for the whole cycle.
//
// Ports:
//   clk       system clock, posedge
//   rst       asynchronous active-low reset
//   op_valid  operation request from execute
//   op        001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO (others ignored)
//   src_a     rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b     rt operand (divisor / multiplier)
//   flush     kills any in-flight operation and blocks an accept in the same cycle
//   busy      pipeline stall, high whenever the FSM is not idle
//   hilo_we   {write HI, write LO}, one-cycle pulse per completed operation
//   hi_wdata  HI write data
//   lo_wdata  LO write data
module mdu_iter #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic [1:0]  hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
);

   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   // Extra product stages beyond the one feeding the output register.
   // The array is kept at one entry minimum so it stays legal when no extra stage exists.
   localparam int unsigned PipeDepth = (MUL_LAT > 2) ? MUL_LAT - 2 : 1;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] opa_q, opa_d;     // multiplicand, or dividend/quotient shift register
   logic [31:0] opb_q, opb_d;     // multiplier, or divisor magnitude
   logic [31:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        mul_sgn_q, mul_sgn_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [1:0]  we_q, we_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] prod_pipe_q [PipeDepth];

   // Multiplier datapath. With MUL_LAT == 1 the product is taken straight from the inputs.
   logic [31:0] mul_x, mul_y;
   logic        mul_sgn;
   logic [63:0] mul_x64, mul_y64, prod_now, prod_fin;

   always_comb begin
      mul_x   = (MUL_LAT == 1) ? src_a : opa_q;
      mul_y   = (MUL_LAT == 1) ? src_b : opb_q;
      mul_sgn = (MUL_LAT == 1) ? (op == OpMult) : mul_sgn_q;
      mul_x64 = mul_sgn ? {{32{mul_x[31]}}, mul_x} : {32'd0, mul_x};
      mul_y64 = mul_sgn ? {{32{mul_y[31]}}, mul_y} : {32'd0, mul_y};
      // The low 64 bits of the extended product are the same for signed and unsigned operands.
      prod_now = mul_x64 * mul_y64;
      prod_fin = (MUL_LAT > 2) ? prod_pipe_q[PipeDepth-1] : prod_now;
   end

   // One restoring-division step: shift in the next dividend bit and try a subtraction.
   logic [32:0] div_shift, div_diff;
   logic        div_ok;
   logic [31:0] rem_step, quo_step, quo_fin, rem_fin;

   always_comb begin
      div_shift = {rem_q, opa_q[31]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ok    = ~div_diff[32];
      rem_step  = div_ok ? div_diff[31:0] : div_shift[31:0];
      quo_step  = {opa_q[30:0], div_ok};
      quo_fin   = neg_quo_q ? (32'd0 - quo_step) : quo_step;
      rem_fin   = neg_rem_q ? (32'd0 - rem_step) : rem_step;
   end

   logic div_sgn;
   assign div_sgn = (op == OpDiv);

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      mul_sgn_d = mul_sgn_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      we_d      = 2'b00;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (op_valid) begin
                  case (op)
                     OpMult, OpMultu: begin
                        opa_d     = src_a;
                        opb_d     = src_b;
                        mul_sgn_d = (op == OpMult);
                        if (MUL_LAT == 1) begin
                           state_d = StDone;
                           we_d    = 2'b11;
                           hi_d    = prod_now[63:32];
                           lo_d    = prod_now[31:0];
                        end else begin
                           state_d = StMul;
                           cnt_d   = 5'(MUL_LAT - 2);
                        end
                     end
                     OpDiv, OpDivu: begin
                        if (src_b == 32'd0) begin
                           state_d = StDone;
                           we_d    = 2'b11;
                           hi_d    = src_a;
                           lo_d    = 32'hFFFF_FFFF;
                        end else begin
                           state_d   = StDiv;
                           opa_d     = (div_sgn && src_a[31]) ? (32'd0 - src_a) : src_a;
                           opb_d     = (div_sgn && src_b[31]) ? (32'd0 - src_b) : src_b;
                           rem_d     = 32'd0;
                           cnt_d     = 5'd0;
                           neg_quo_d = div_sgn && (src_a[31] ^ src_b[31]);
                           neg_rem_d = div_sgn && src_a[31];
                        end
                     end
                     OpMthi: begin
                        we_d = 2'b10;
                        hi_d = src_a;
                     end
                     OpMtlo: begin
                        we_d = 2'b01;
                        lo_d = src_a;
                     end
                     default: ;
                  endcase
               end
            end
            StMul: begin
               if (cnt_q == 5'd0) begin
                  state_d = StDone;
                  we_d    = 2'b11;
                  hi_d    = prod_fin[63:32];
                  lo_d    = prod_fin[31:0];
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            StDiv: begin
               opa_d = quo_step;
               rem_d = rem_step;
               if (cnt_q == 5'd31) begin
                  state_d = StDone;
                  we_d    = 2'b11;
                  hi_d    = rem_fin;
                  lo_d    = quo_fin;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         opa_q     <= 32'd0;
         opb_q     <= 32'd0;
         rem_q     <= 32'd0;
         cnt_q     <= 5'd0;
         mul_sgn_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         we_q      <= 2'b00;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         mul_sgn_q <= mul_sgn_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         we_q      <= we_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Free-running product pipeline; the FSM counter picks the right cycle to sample it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < PipeDepth; i++) prod_pipe_q[i] <= 64'd0;
      end else begin
         prod_pipe_q[0] <= prod_now;
         for (int unsigned i = 1; i < PipeDepth; i++) prod_pipe_q[i] <= prod_pipe_q[i-1];
      end
   end

   assign busy     = (state_q != StIdle);
   assign hilo_we  = we_q;
   assign hi_wdata = hi_q;
   assign lo_wdata = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: directed vectors with a write scoreboard.
// Each issued operation pushes its expected write (data and cycle); a negedge monitor pops
// and compares every write the DUT presents, and flags writes nobody expected.
module tb_mdu_iter;

   localparam int unsigned MUL_LAT = 2;
   localparam int unsigned DIV_LAT = 33;

   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        busy;
   logic [1:0]  hilo_we;
   logic [31:0] hi_wdata, lo_wdata;

   mdu_iter #(.MUL_LAT(MUL_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .busy     (busy),
      .hilo_we  (hilo_we),
      .hi_wdata (hi_wdata),
      .lo_wdata (lo_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Write monitor.
   always @(negedge clk) begin
      if (hilo_we !== 2'b00) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got we=%b hi=%h lo=%h at cycle %0d, want no write",
                     hilo_we, hi_wdata, lo_wdata, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("write_we", 64'(hilo_we), 64'(mon_e.we));
            check("write_hi", 64'(hi_wdata), 64'(mon_e.hi));
            check("write_lo", 64'(lo_wdata), 64'(mon_e.lo));
            check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic idle_inputs();
      op_valid = 1'b0;
      op       = 3'b000;
      src_a    = 32'd0;
      src_b    = 32'd0;
      flush    = 1'b0;
   endtask

   // Drive one request through the next posedge; push the expected write (if any).
   // lat counts cycles from the accept edge to the cycle the write is visible.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] we, input logic [31:0] hi, input logic [31:0] lo,
                        input int unsigned lat);
      exp_t e;
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      @(posedge clk);
      #1;
      if (we != 2'b00) begin
         if (we[1]) model_hi = hi;
         if (we[0]) model_lo = lo;
         e.we  = we;
         e.hi  = model_hi;
         e.lo  = model_lo;
         e.cyc = cyc + lat - 1;
         sb.push_back(e);
      end
   endtask

   // busy must be high for exactly n cycles after the accept edge, then low.
   task automatic busy_run(input string name, input int unsigned n);
      for (int unsigned i = 0; i <= n; i++) begin
         @(negedge clk);
         check(name, 64'(busy), 64'(i < n));
      end
   endtask

   task automatic wait_idle(input string name, input int unsigned budget);
      int unsigned k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 64'(busy), 64'd0);
   endtask

   task automatic drain(input string name, input int unsigned budget);
      int unsigned k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_we", 64'(hilo_we), 64'd0);
      check("reset_hi", 64'(hi_wdata), 64'd0);
      check("reset_lo", 64'(lo_wdata), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Multiply: -2 * 3 = -6, and max unsigned squared.
      issue(OpMult, 32'hFFFF_FFFE, 32'd3, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
      idle_inputs();
      busy_run("mult_busy", MUL_LAT);
      issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 32'h0000_0001,
            MUL_LAT);
      idle_inputs();
      busy_run("multu_busy", MUL_LAT);

      // Signed divide -7 / 2 = -3 rem -1.
      issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      idle_inputs();
      busy_run("div_busy", DIV_LAT);

      // Unsigned 100 / 7 = 14 rem 2, with an MTHI request ignored while busy.
      issue(OpDivu, 32'd100, 32'd7, 2'b11, 32'd2, 32'd14, DIV_LAT);
      idle_inputs();
      repeat (5) @(negedge clk);
      op_valid = 1'b1;
      op       = OpMthi;
      src_a    = 32'hDEAD_BEEF;
      @(negedge clk);
      idle_inputs();
      wait_idle("divu_idle", 60);
      drain("divu_write", 5);

      // Signed overflow case wraps without a trap.
      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'd0, 32'h8000_0000, DIV_LAT);
      idle_inputs();
      busy_run("div_ovf_busy", DIV_LAT);

      // Divide by zero short-circuits straight to the write.
      issue(OpDivu, 32'h0000_1234, 32'd0, 2'b11, 32'h0000_1234, 32'hFFFF_FFFF, 1);
      idle_inputs();
      busy_run("div0_busy", 1);

      // MTHI then MTLO on consecutive cycles; LO is held from the divide above.
      issue(OpMthi, 32'hA5A5_A5A5, 32'd0, 2'b10, 32'hA5A5_A5A5, 32'd0, 1);
      check("mthi_busy", 64'(busy), 64'd0);
      issue(OpMtlo, 32'h5A5A_5A5A, 32'd0, 2'b01, 32'd0, 32'h5A5A_5A5A, 1);
      idle_inputs();
      busy_run("mtlo_busy", 0);
      drain("mthi_mtlo_write", 5);

      // Flush in the middle of a divide: no write may follow.
      issue(OpDiv, 32'd1000, 32'd3, 2'b00, 32'd0, 32'd0, 0);
      idle_inputs();
      repeat (18) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_div_busy", 64'(busy), 64'd0);
      check("flush_div_we", 64'(hilo_we), 64'd0);
      repeat (40) @(negedge clk);
      check("flush_div_idle", 64'(busy), 64'd0);

      // Flush on the edge that would enter DONE.
      issue(OpMult, 32'd5, 32'd7, 2'b00, 32'd0, 32'd0, 0);
      idle_inputs();
      repeat (MUL_LAT - 2) @(posedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_done_we", 64'(hilo_we), 64'd0);
      check("flush_done_busy", 64'(busy), 64'd0);
      repeat (4) @(negedge clk);

      // Flush together with op_valid: nothing is accepted.
      op_valid = 1'b1;
      op       = OpMult;
      src_a    = 32'd2;
      src_b    = 32'd2;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      check("flush_accept_busy", 64'(busy), 64'd0);
      op       = OpMthi;
      src_a    = 32'h1111_1111;
      @(posedge clk);
      #1;
      check("flush_mthi_we", 64'(hilo_we), 64'd0);
      idle_inputs();

      // Illegal opcode is ignored.
      op_valid = 1'b1;
      op       = 3'b111;
      src_a    = 32'h2222_2222;
      @(posedge clk);
      #1;
      idle_inputs();
      check("illegal_busy", 64'(busy), 64'd0);
      check("illegal_we", 64'(hilo_we), 64'd0);
      @(negedge clk);

      // Reset in the middle of a divide.
      issue(OpDivu, 32'd100, 32'd7, 2'b00, 32'd0, 32'd0, 0);
      idle_inputs();
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_we", 64'(hilo_we), 64'd0);
      check("rst_hi", 64'(hi_wdata), 64'd0);
      check("rst_lo", 64'(lo_wdata), 64'd0);
      model_hi = 32'd0;
      model_lo = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_no_op_busy", 64'(busy), 64'd0);

      // Unit still works after reset: 0x10000 * 0x10000 = 2^32.
      issue(OpMultu, 32'h0001_0000, 32'h0001_0000, 2'b11, 32'd1, 32'd0, MUL_LAT);
      idle_inputs();
      busy_run("post_rst_busy", MUL_LAT);
      drain("final_drain", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
